// File: rtl/lc4_free_list_ck_pkg.sv
// lc4_free_list_ck_pkg: shared sizing defaults and update-priority encoding for the free list
package lc4_free_list_ck_pkg;
    localparam int FL_N       = 16;
    localparam int FL_LOGN    = 4;
    localparam int FL_NARCH   = 8;
    localparam int FL_ALLOC_W = 2;
    localparam int FL_NCK     = 4;
    localparam int FL_LOGCK   = 2;
    typedef enum logic [1:0] {
        OP_NORMAL,
        OP_RESTORE,
        OP_FLUSH
    } fl_op_e;
endpackage

// File: rtl/lc4_free_list_ck_pick.sv
// lc4_free_list_ck_pick: MSB-first picker returning W distinct set-bit indices and their valid mask
module lc4_free_list_ck_pick #(
    parameter int N    = 16,
    parameter int LOGN = 4,
    parameter int W    = 2
) (
    input  logic [N-1:0]      mask,
    output logic [W*LOGN-1:0] idx,
    output logic [W-1:0]      vld
);
    logic [N-1:0] m;
    // each slot takes the highest remaining set bit, then removes it for the next slot
    always_comb begin
        m   = mask;
        idx = '0;
        vld = '0;
        for (int s = 0; s < W; s++) begin
            for (int b = 0; b < N; b++) begin
                if (m[b]) begin
                    idx[s*LOGN +: LOGN] = LOGN'(b);
                    vld[s] = 1'b1;
                end
            end
            if (vld[s]) m[idx[s*LOGN +: LOGN]] = 1'b0;
        end
    end
endmodule

// File: rtl/lc4_free_list_ck.sv
// lc4_free_list_ck: multi-port physical register free list with architectural recovery and branch checkpoints
module lc4_free_list_ck
    import lc4_free_list_ck_pkg::*;
#(
    parameter int N       = FL_N,
    parameter int LOGN    = FL_LOGN,
    parameter int NARCH   = FL_NARCH,
    parameter int ALLOC_W = FL_ALLOC_W,
    parameter int NCK     = FL_NCK,
    parameter int LOGCK   = FL_LOGCK
) (
    input  logic                    clk,
    input  logic                    gwe,
    input  logic                    rst,
    input  logic [ALLOC_W-1:0]      alloc_req,
    output logic                    alloc_ready,
    output logic [ALLOC_W*LOGN-1:0] alloc_preg,
    input  logic [ALLOC_W-1:0]      commit_valid,
    input  logic [ALLOC_W*LOGN-1:0] commit_old,
    input  logic [ALLOC_W*LOGN-1:0] commit_new,
    input  logic                    flush,
    input  logic                    ck_take,
    input  logic [LOGCK-1:0]        ck_id,
    input  logic                    ck_restore,
    input  logic [LOGCK-1:0]        ck_rid,
    output logic                    full,
    output logic [LOGN:0]           free_count
);
    localparam logic [N-1:0] RST_MASK = {{(N-NARCH){1'b1}}, {NARCH{1'b0}}};

    logic [N-1:0]       free_q, free_d, arch_q, arch_d, arch_c, cm, am;
    logic [N-1:0]       snap_q [NCK];
    logic [N-1:0]       snap_d [NCK];
    logic [N-1:0]       snap_c [NCK];
    logic [NCK-1:0]     sv_q, sv_d;
    logic [ALLOC_W-1:0] pv;
    fl_op_e             op;

    lc4_free_list_ck_pick #(.N(N), .LOGN(LOGN), .W(ALLOC_W)) u_pick (
        .mask(free_q),
        .idx (alloc_preg),
        .vld (pv)
    );

    assign free_count  = (LOGN+1)'($countones(free_q));
    assign full        = free_q == '0;
    assign alloc_ready = free_count >= (LOGN+1)'(ALLOC_W);

    // flush beats restore; a restore from an invalid slot falls through to normal operation
    always_comb op = flush ? OP_FLUSH : (ck_restore && sv_q[ck_rid]) ? OP_RESTORE : OP_NORMAL;

    // commit effects on the architectural mask and valid snapshots, plus this cycle's grants
    always_comb begin
        arch_c = arch_q;
        cm     = '0;
        am     = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            if (commit_valid[i]) begin
                arch_c[commit_old[i*LOGN +: LOGN]] = 1'b1;
                arch_c[commit_new[i*LOGN +: LOGN]] = 1'b0;
                cm[commit_old[i*LOGN +: LOGN]]     = 1'b1;
            end
            if (alloc_req[i] && alloc_ready && pv[i]) am[alloc_preg[i*LOGN +: LOGN]] = 1'b1;
        end
        for (int j = 0; j < NCK; j++) snap_c[j] = sv_q[j] ? snap_q[j] | cm : snap_q[j];
    end

    // next-state selection by priority; a new checkpoint captures the post-allocation mask
    always_comb begin
        arch_d = arch_c;
        snap_d = snap_c;
        sv_d   = sv_q;
        free_d = (free_q | cm) & ~am;
        case (op)
            OP_FLUSH: begin
                free_d = arch_c;
                sv_d   = '0;
            end
            OP_RESTORE: begin
                free_d        = snap_q[ck_rid] | cm;
                sv_d[ck_rid]  = 1'b0;
            end
            default: begin
                if (ck_take) begin
                    snap_d[ck_id] = free_d;
                    sv_d[ck_id]   = 1'b1;
                end
            end
        endcase
    end

    // all state moves only under gwe; reset is likewise qualified by gwe
    always_ff @(posedge clk) begin
        if (gwe && rst) begin
            free_q <= RST_MASK;
            arch_q <= RST_MASK;
            sv_q   <= '0;
            for (int j = 0; j < NCK; j++) snap_q[j] <= RST_MASK;
        end else if (gwe) begin
            free_q <= free_d;
            arch_q <= arch_d;
            sv_q   <= sv_d;
            for (int j = 0; j < NCK; j++) snap_q[j] <= snap_d[j];
        end
    end
endmodule

// File: tb/tb_lc4_free_list_ck.sv
// tb_lc4_free_list_ck: directed and random checks of the free list against a mask-level reference model
module tb_lc4_free_list_ck;
    localparam int N = 16, LOGN = 4, NARCH = 8, W = 2, NCK = 4, LOGCK = 2;
    localparam logic [N-1:0] RST = 16'hff00;

    logic clk = 1'b0;
    logic gwe, rst, flush, ck_take, ck_restore, alloc_ready, full;
    logic [W-1:0] alloc_req, commit_valid;
    logic [W*LOGN-1:0] commit_old, commit_new, alloc_preg;
    logic [LOGCK-1:0] ck_id, ck_rid;
    logic [LOGN:0] free_count;

    int errors = 0, checks = 0;

    logic [N-1:0] mf, ma;
    logic [N-1:0] ms [NCK];
    logic mv [NCK];

    lc4_free_list_ck dut (
        .clk(clk), .gwe(gwe), .rst(rst),
        .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_preg(alloc_preg),
        .commit_valid(commit_valid), .commit_old(commit_old), .commit_new(commit_new),
        .flush(flush), .ck_take(ck_take), .ck_id(ck_id),
        .ck_restore(ck_restore), .ck_rid(ck_rid),
        .full(full), .free_count(free_count)
    );

    always #5 clk = ~clk;

    function automatic int mcount();
        int k = 0;
        for (int b = 0; b < N; b++) if (mf[b]) k++;
        return k;
    endfunction

    function automatic int mpick(input int s);
        int k = 0;
        for (int b = N-1; b >= 0; b--) begin
            if (mf[b]) begin
                if (k == s) return b;
                k++;
            end
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic [N-1:0] cm, am;
        int p;
        cm = '0;
        am = '0;
        if (!gwe) return;
        if (rst) begin
            mf = RST;
            ma = RST;
            for (int j = 0; j < NCK; j++) begin
                ms[j] = RST;
                mv[j] = 1'b0;
            end
            return;
        end
        for (int i = 0; i < W; i++) begin
            if (commit_valid[i]) begin
                ma[commit_old[i*LOGN +: LOGN]] = 1'b1;
                ma[commit_new[i*LOGN +: LOGN]] = 1'b0;
                cm[commit_old[i*LOGN +: LOGN]] = 1'b1;
            end
        end
        for (int j = 0; j < NCK; j++) if (mv[j]) ms[j] = ms[j] | cm;
        if (flush) begin
            mf = ma;
            for (int j = 0; j < NCK; j++) mv[j] = 1'b0;
        end else if (ck_restore && mv[ck_rid]) begin
            mf = ms[ck_rid] | cm;
            mv[ck_rid] = 1'b0;
        end else begin
            if (mcount() >= W) begin
                for (int i = 0; i < W; i++) begin
                    if (alloc_req[i]) begin
                        p = mpick(i);
                        am[p] = 1'b1;
                    end
                end
            end
            mf = (mf | cm) & ~am;
            if (ck_take) begin
                ms[ck_id] = mf;
                mv[ck_id] = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_cnt"}, 32'(free_count), 32'(mcount()));
        chk({tag, "_full"}, 32'(full), 32'(mf == '0));
        chk({tag, "_rdy"}, 32'(alloc_ready), 32'(mcount() >= W));
        for (int s = 0; s < W; s++)
            if (mpick(s) >= 0) chk($sformatf("%s_pick%0d", tag, s), 32'(alloc_preg[s*LOGN +: LOGN]), 32'(mpick(s)));
    endtask

    task automatic cyc(input string tag);
        model_update();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        gwe = 1'b1; rst = 1'b0; flush = 1'b0;
        ck_take = 1'b0; ck_id = '0; ck_restore = 1'b0; ck_rid = '0;
        alloc_req = '0; commit_valid = '0; commit_old = '0; commit_new = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc("rst");
        idle();
    endtask

    initial begin
        int v [4];
        int n, r;
        bit dup;
        mf = '0; ma = '0;
        for (int j = 0; j < NCK; j++) begin
            ms[j] = '0;
            mv[j] = 1'b0;
        end
        idle();
        #1;
        do_reset();
        chk("rst_cnt_k", 32'(free_count), 8);
        chk("rst_p0_k", 32'(alloc_preg[3:0]), 15);
        chk("rst_p1_k", 32'(alloc_preg[7:4]), 14);
        chk("rst_full_k", 32'(full), 0);

        alloc_req = 2'b11;
        for (int k = 0; k < 4; k++) cyc("drain");
        chk("empty_cnt_k", 32'(free_count), 0);
        chk("empty_full_k", 32'(full), 1);
        chk("empty_rdy_k", 32'(alloc_ready), 0);
        cyc("drain5");

        commit_valid = 2'b01; commit_old = 8'h03; commit_new = 8'h0f;
        cyc("free3");
        idle();
        chk("free3_cnt_k", 32'(free_count), 1);
        chk("free3_p0_k", 32'(alloc_preg[3:0]), 3);
        chk("free3_rdy_k", 32'(alloc_ready), 0);

        do_reset();
        ck_take = 1'b1; ck_id = 2'd1; alloc_req = 2'b11;
        cyc("ck_take");
        idle(); alloc_req = 2'b11;
        cyc("ck_alloc");
        idle(); commit_valid = 2'b01; commit_old = 8'h05; commit_new = 8'h0f;
        cyc("ck_commit");
        idle(); ck_restore = 1'b1; ck_rid = 2'd1;
        cyc("ck_restore");
        chk("restore_cnt_k", 32'(free_count), 7);
        chk("restore_p0_k", 32'(alloc_preg[3:0]), 13);
        alloc_req = 2'b11;
        cyc("restore_again");
        chk("restore_noop_k", 32'(free_count), 5);

        do_reset();
        alloc_req = 2'b11; ck_take = 1'b1; ck_id = 2'd2;
        cyc("fl_alloc");
        idle(); commit_valid = 2'b01; commit_old = 8'h02; commit_new = 8'h0f;
        cyc("fl_commit");
        idle(); flush = 1'b1;
        cyc("flush");
        chk("flush_cnt_k", 32'(free_count), 8);
        chk("flush_p0_k", 32'(alloc_preg[3:0]), 14);
        idle(); ck_restore = 1'b1; ck_rid = 2'd2;
        cyc("fl_restore");
        chk("fl_restore_k", 32'(free_count), 8);

        idle(); alloc_req = 2'b11;
        cyc("pre_gwe");
        gwe = 1'b0; rst = 1'b1; flush = 1'b1;
        commit_valid = 2'b01; commit_old = 8'h0e; commit_new = 8'h0d;
        cyc("gwe0");
        chk("gwe0_cnt_k", 32'(free_count), 6);
        gwe = 1'b1;
        cyc("gwe1");
        chk("gwe1_cnt_k", 32'(free_count), 8);

        for (int c = 0; c < 400; c++) begin
            idle();
            gwe = $urandom_range(0, 9) != 0;
            rst = $urandom_range(0, 49) == 0;
            flush = $urandom_range(0, 19) == 0;
            alloc_req = W'($urandom);
            ck_take = $urandom_range(0, 3) == 0;
            ck_id = LOGCK'($urandom);
            ck_restore = $urandom_range(0, 7) == 0;
            ck_rid = LOGCK'($urandom);
            n = 0;
            for (int t = 0; t < 40 && n < 4; t++) begin
                r = $urandom_range(0, N-1);
                dup = 1'b0;
                for (int k = 0; k < n; k++) if (v[k] == r) dup = 1'b1;
                if (!mf[r] && !dup) begin
                    v[n] = r;
                    n++;
                end
            end
            if (n >= 2 && $urandom_range(0, 1) == 1) begin
                commit_valid[0] = 1'b1;
                commit_old[3:0] = LOGN'(v[0]);
                commit_new[3:0] = LOGN'(v[1]);
            end
            if (n >= 4 && $urandom_range(0, 1) == 1) begin
                commit_valid[1] = 1'b1;
                commit_old[7:4] = LOGN'(v[2]);
                commit_new[7:4] = LOGN'(v[3]);
            end
            cyc("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
